// File: rtl/font_rom_arbiter_pkg.sv
// Shared definitions for the font ROM arbiter and its round-robin sub-module.
// Widths of the font ROM port, the wait-counter width and the tag-width helper.
package font_rom_arbiter_pkg;

  // Font ROM geometry: address is {char_code[6:0], char_line[3:0]}, data is one pixel line.
  localparam int FONT_ADDR_W = 11;
  localparam int FONT_DATA_W = 8;

  // Per-requester wait counters saturate at 255.
  localparam int WAIT_CNT_W = 8;

  // Width of a requester index (the response tag); at least one bit.
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/font_rom_arbiter_rr_arbiter.sv
// rr_arbiter: combinational one-hot grant with a wrap-around priority search.
// The search starts at i_ptr and wraps modulo N_REQ; the first active request wins.
// Driving i_ptr with a constant zero turns it into a fixed-priority arbiter.
module rr_arbiter
  import font_rom_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = tag_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Walk all N_REQ positions from the pointer and grant the first requester found.
  always_comb begin
    int               v_sum;
    logic [IDX_W-1:0] v_pos;
    // NOTE: every output gets a default before the search; a path that skips an assignment would infer a latch.
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    v_sum = 0;
    v_pos = '0;
    for (int k = 0; k < N_REQ; k++) begin
      v_sum = int'(i_ptr) + k;
      if (v_sum >= N_REQ) v_sum = v_sum - N_REQ;
      v_pos = IDX_W'(v_sum);
      if (!o_any && i_req[v_pos]) begin
        o_gnt[v_pos] = 1'b1;
        o_idx        = v_pos;
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one registered-read font ROM among N_REQ text units.
// Round-robin grant (combinational), address mux, one-cycle tag pipeline that routes
// the ROM data back as a one-hot rvalid, and sticky per-requester starvation flags.
// Build option: define FONT_ARB_FIXED_PRIO_EN to drop the round-robin pointer and use
// fixed priority (requester 0 highest); the starvation flags then show unfairness.
module font_rom_arbiter
  import font_rom_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = FONT_ADDR_W,
  parameter int DATA_W   = FONT_DATA_W,
  parameter int MAX_WAIT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic [N_REQ-1:0]        starve
);

  localparam int                    IDX_W      = tag_w(N_REQ);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_SAT   = '1;

  logic [IDX_W-1:0]      w_ptr;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_any;
  logic [ADDR_W-1:0]     w_addr_sel;
  logic [ADDR_W-1:0]     r_rom_addr;
  logic                  r_tag_valid;
  logic [IDX_W-1:0]      r_tag_idx;
  logic [WAIT_CNT_W-1:0] r_wait_cnt  [N_REQ];
  logic [WAIT_CNT_W-1:0] w_wait_next [N_REQ];
  logic [N_REQ-1:0]      r_starve;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req (req),
    .i_ptr (w_ptr),
    .o_gnt (gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

`ifdef FONT_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at requester 0.
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr;

  // Round-robin pointer moves to the requester after the one just granted.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values whatever the block order.
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // Granted requester's address goes to the ROM; with no grant the last address is held.
  assign w_addr_sel = req_addr[int'(w_idx) * ADDR_W +: ADDR_W];
  assign rom_addr   = w_any ? w_addr_sel : r_rom_addr;

  // Remember the last granted address for idle cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rom_addr <= '0;
    end else if (w_any) begin
      r_rom_addr <= w_addr_sel;
    end
  end

  // Tag pipeline: {valid, idx} of this cycle's grant, aligned with the ROM's read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tag_valid <= 1'b0;
      r_tag_idx   <= '0;
    end else begin
      r_tag_valid <= w_any;
      r_tag_idx   <= w_idx;
    end
  end

  // Route the ROM response to the tagged requester; reset suppresses an in-flight response.
  always_comb begin
    rvalid = '0;
    if (rst && r_tag_valid) rvalid[r_tag_idx] = 1'b1;
  end

  assign rdata = (rst && r_tag_valid) ? rom_data : '0;

  // Next wait count: clear on grant or idle, otherwise count up and saturate.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_wait_next[i] = r_wait_cnt[i];
      if (gnt[i] || !req[i]) begin
        w_wait_next[i] = '0;
      end else if (r_wait_cnt[i] != WAIT_SAT) begin
        w_wait_next[i] = r_wait_cnt[i] + 1'b1;
      end
    end
  end

  // Wait counters and sticky starvation flags; a flag sets on the edge the count reaches MAX_WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: this counter array is flops, not a RAM; its zero state is observable behaviour, so it is cleared here.
      for (int i = 0; i < N_REQ; i++) r_wait_cnt[i] <= '0;
      r_starve <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        r_wait_cnt[i] <= w_wait_next[i];
        if (w_wait_next[i] >= WAIT_LIMIT) r_starve[i] <= 1'b1;
      end
    end
  end

  assign starve = r_starve;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Testbench for font_rom_arbiter (N_REQ=4, MAX_WAIT=15) with a model font ROM.
// Directed vectors check grant/address/starve each cycle; expected responses go into a
// queue that a separate monitor pops whenever rvalid is seen.
// Expectations follow FONT_ARB_FIXED_PRIO_EN when the bench is built with that macro.
module tb_font_rom_arbiter;

`ifdef FONT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [43:0] req_addr;
  logic [3:0]  gnt;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [3:0]  rvalid;
  logic [7:0]  rdata;
  logic [3:0]  starve;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [10:0] last_addr = 11'h000;
  logic [10:0] addr_tab [4];

  font_rom_arbiter #(
    .N_REQ    (4),
    .ADDR_W   (11),
    .DATA_W   (8),
    .MAX_WAIT (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .starve   (starve)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Arbitrary but address-dependent contents for the model ROM.
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], a[10:6]};
  endfunction

  // Model font ROM: one-cycle registered read.
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rvalid must match the oldest queued response, in the cycle it is due.
  always @(negedge clk) begin
    exp_t e;
    if (rvalid !== 4'b0000) begin
      if (q.size() == 0) begin
        check("rvalid_unexpected", 32'(rvalid), 32'h0);
      end else begin
        e = q.pop_front();
        check("rvalid", 32'(rvalid), 32'(1 << e.idx));
        check("rdata", 32'(rdata), 32'(e.data));
        check("resp_cycle", cyc, e.due);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check("rvalid_missing", 32'(rvalid), 32'(1 << e.idx));
    end
  end

  // One clock of stimulus: drive after the edge, check combinational outputs mid-cycle.
  task automatic step(input logic rst_v, input logic [3:0] req_v, input logic [3:0] exp_gnt,
                      input logic [3:0] exp_starve, input bit expect_resp, input string name);
    int          idx;
    logic [10:0] a;
    exp_t        e;
    @(posedge clk);
    #1;
    rst = rst_v;
    req = req_v;
    @(negedge clk);
    check({name, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    check({name, "_starve"}, 32'(starve), 32'(exp_starve));
    idx = -1;
    for (int i = 0; i < 4; i++) if (exp_gnt[i]) idx = i;
    if (!rst_v) begin
      check({name, "_rvalid_rst"}, 32'(rvalid), 32'h0);
      check({name, "_rdata_rst"}, 32'(rdata), 32'h0);
      last_addr = 11'h000;
    end else if (idx >= 0) begin
      a = addr_tab[idx];
      check({name, "_rom_addr"}, 32'(rom_addr), 32'(a));
      last_addr = a;
      if (expect_resp) begin
        e.idx  = idx;
        e.data = rom_fn(a);
        e.due  = cyc + 1;
        q.push_back(e);
      end
    end else begin
      check({name, "_rom_addr_hold"}, 32'(rom_addr), 32'(last_addr));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    addr_tab[0] = 11'h041;
    addr_tab[1] = 11'h1F7;
    addr_tab[2] = 11'h2A3;
    addr_tab[3] = 11'h7FF;
    req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};

    // Reset held three cycles with every requester asking: grants show, responses do not.
    for (int k = 0; k < 3; k++) step(1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b0, "reset");

    // All-request rotation from ptr=0: 0,1,2,3,0,1,2,3 (fixed priority: always 0).
    for (int k = 0; k < 8; k++) begin
      g = FIXED ? 4'b0001 : 4'(1 << (k % 4));
      step(1'b1, 4'b1111, g, 4'b0000, 1'b1, "rotate");
    end
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "idle1");

    // Single request from requester 2 at 11'h2A3; leaves ptr=3.
    step(1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, "single");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "idle2");

    // Wrap and skip from ptr=3 with req=0101: 0001, 0100, 0001 (fixed: 0001 each time).
    step(1'b1, 4'b0101, 4'b0001, 4'b0000, 1'b1, "wrap0");
    step(1'b1, 4'b0101, FIXED ? 4'b0001 : 4'b0100, 4'b0000, 1'b1, "wrap1");
    step(1'b1, 4'b0101, 4'b0001, 4'b0000, 1'b1, "wrap2");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "idle3");

    // Requesters 0 and 1 held 20 cycles from ptr=1: alternate 1,0,... under round-robin.
    // Fixed priority starves requester 1; its flag shows from the 16th waiting cycle.
    for (int k = 1; k <= 20; k++) begin
      g = FIXED ? 4'b0001 : ((k % 2) == 1 ? 4'b0010 : 4'b0001);
      step(1'b1, 4'b0011, g, (FIXED && k >= 16) ? 4'b0010 : 4'b0000, 1'b1, "starve");
    end

    // Reset mid-flight: grant 2, then reset; its response is dropped and ptr restarts at 0.
    step(1'b1, 4'b0100, 4'b0100, FIXED ? 4'b0010 : 4'b0000, 1'b0, "mid_gnt");
    step(1'b0, 4'b0000, 4'b0000, FIXED ? 4'b0010 : 4'b0000, 1'b0, "mid_rst");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "mid_rst2");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "post_idle");
    step(1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b1, "post0");
    step(1'b1, 4'b1111, FIXED ? 4'b0001 : 4'b0010, 4'b0000, 1'b1, "post1");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "drain0");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "drain1");

    check("queue_empty", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
